// File: rtl/cp0_pkg.sv
// Shared constants for the second-generation coprocessor 0.
// Holds register addresses, SR/Cause field positions and exception codes
// used by cp0_v2 and cp0_timer.
package cp0_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned EXC_W  = 5;

    // CP0 register numbers
    localparam logic [ADDR_W-1:0] REG_BADVADDR = 5'd8;
    localparam logic [ADDR_W-1:0] REG_COUNT    = 5'd9;
    localparam logic [ADDR_W-1:0] REG_COMPARE  = 5'd11;
    localparam logic [ADDR_W-1:0] REG_SR       = 5'd12;
    localparam logic [ADDR_W-1:0] REG_CAUSE    = 5'd13;
    localparam logic [ADDR_W-1:0] REG_EPC      = 5'd14;
    localparam logic [ADDR_W-1:0] REG_PRID     = 5'd15;

    // SR field positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 8;

    // Cause field positions
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_EXC_LO = 2;

    // Bit positions inside the 8-bit IP/IM field
    localparam int unsigned IP_SW_LO = 0;
    localparam int unsigned IP_HW_LO = 2;
    localparam int unsigned IP_TI    = 7;

    typedef enum logic [EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Restart address: a delay-slot instruction restarts at its branch.
    function automatic logic [DATA_W-1:0] restart_pc(input logic [DATA_W-1:0] pc,
                                                     input logic in_ds);
        return in_ds ? (pc - DATA_W'(4)) : pc;
    endfunction

endpackage

// File: rtl/cp0_v2_if.sv
// Pipeline <-> CP0 connection bundle.
// master: pipeline side (drives access/commit info, receives int_req/epc/rd).
// slave : CP0 side.
interface cp0_v2_if #(
    parameter int unsigned N_HWINT = 5
) ();

    logic [4:0]         ra;
    logic [31:0]        rd;
    logic               we;
    logic [4:0]         wa;
    logic [31:0]        wd;
    logic [31:0]        pc;
    logic               in_ds;
    logic [4:0]         exc_code_in;
    logic               bad_vaddr_vld;
    logic [31:0]        bad_vaddr_in;
    logic [N_HWINT-1:0] hw_int;
    logic               eret;
    logic               int_req;
    logic [31:0]        epc_out;
    logic               timer_irq;

    modport master (
        output ra, we, wa, wd, pc, in_ds, exc_code_in,
               bad_vaddr_vld, bad_vaddr_in, hw_int, eret,
        input  rd, int_req, epc_out, timer_irq
    );

    modport slave (
        input  ra, we, wa, wd, pc, in_ds, exc_code_in,
               bad_vaddr_vld, bad_vaddr_in, hw_int, eret,
        output rd, int_req, epc_out, timer_irq
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with prescaler and timer-interrupt flag.
// Ports: clk, reset_n (sync, active-low); i_cnt_we / i_cmp_we write strobes
// with shared data i_wd; o_count, o_compare current values; o_ti timer flag.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned CNT_DIV_LOG2 = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_cnt_we,
    input  logic              i_cmp_we,
    input  logic [DATA_W-1:0] i_wd,
    output logic [DATA_W-1:0] o_count,
    output logic [DATA_W-1:0] o_compare,
    output logic              o_ti
);

    localparam int unsigned PRE_W = (CNT_DIV_LOG2 == 0) ? 1 : CNT_DIV_LOG2;

    logic [PRE_W-1:0]  r_presc;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_compare;
    logic              r_ti;
    logic              w_tick;
    logic [PRE_W-1:0]  w_presc_nxt;

    // Count advances when the prescaler wraps; with no division it advances every clock.
    always_comb begin
        w_tick      = 1'b1;
        w_presc_nxt = '0;
        if (CNT_DIV_LOG2 != 0) begin
            w_tick      = (r_presc == {PRE_W{1'b1}});
            w_presc_nxt = r_presc + PRE_W'(1);
        end
    end

    // Register writes take precedence over the free-running update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '1;
            r_ti      <= 1'b0;
        end else begin
            if (i_cnt_we) begin
                r_count <= i_wd;
                r_presc <= '0;
            end else begin
                r_presc <= w_presc_nxt;
                if (w_tick) begin
                    r_count <= r_count + DATA_W'(1);
                end
            end

            if (i_cmp_we) begin
                r_compare <= i_wd;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_v2.sv
// Coprocessor 0, second generation: SR, Cause, EPC, PRId, BadVAddr and a
// Count/Compare timer; raises int_req to the pipeline controller.
// Ports: clk, reset_n (sync, active-low); bus (cp0_v2_if.slave) carrying
// mfc0/mtc0 access, M-stage commit info, hw_int lines, eret, and the
// int_req / epc_out / timer_irq / rd results.
module cp0_v2
    import cp0_pkg::*;
#(
    parameter int unsigned N_HWINT      = 5,
    parameter int unsigned CNT_DIV_LOG2 = 1,
    parameter logic [31:0] PRID_VAL     = 32'h2037_3168,
    parameter logic [31:0] SR_RESET     = 32'h0000_FF11
) (
    input  logic       clk,
    input  logic       reset_n,
    cp0_v2_if.slave    bus
);

    logic [DATA_W-1:0]  r_sr;
    logic [DATA_W-1:0]  r_epc;
    logic [DATA_W-1:0]  r_badvaddr;
    logic               r_bd;
    logic [1:0]         r_ip_sw;
    logic [N_HWINT-1:0] r_ip_hw;
    logic [EXC_W-1:0]   r_exc_code;

    logic [DATA_W-1:0]  w_count;
    logic [DATA_W-1:0]  w_compare;
    logic               w_ti;
    logic [7:0]         w_ip;
    logic [DATA_W-1:0]  w_cause;
    logic               w_pend;
    logic               w_dev_req;
    logic               w_exc_req;
    logic               w_int_req;
    logic               w_wr_ok;
    logic               w_cnt_we;
    logic               w_cmp_we;
    logic [DATA_W-1:0]  w_rd;

    // Assemble IP: software bits, sampled hardware lines, timer in the top bit.
    always_comb begin
        w_ip                        = '0;
        w_ip[IP_SW_LO +: 2]         = r_ip_sw;
        w_ip[IP_HW_LO +: N_HWINT]   = r_ip_hw;
        w_ip[IP_TI]                 = w_ti;
    end

    assign w_cause = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exc_code, 2'b00};

    // Request logic; eret suppresses any request in its own cycle.
    always_comb begin
        w_pend    = |(w_ip & r_sr[SR_IM_LO +: 8]);
        w_dev_req = w_pend & r_sr[SR_IE] & ~r_sr[SR_EXL];
        w_exc_req = (bus.exc_code_in != '0) & ~r_sr[SR_EXL];
        w_int_req = (w_dev_req | w_exc_req) & ~bus.eret;
    end

    // A faulting or interrupted instruction does not commit its mtc0.
    assign w_wr_ok  = bus.we & ~w_int_req;
    assign w_cnt_we = w_wr_ok & (bus.wa == REG_COUNT);
    assign w_cmp_we = w_wr_ok & (bus.wa == REG_COMPARE);

    cp0_timer #(
        .CNT_DIV_LOG2 (CNT_DIV_LOG2)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_cnt_we  (w_cnt_we),
        .i_cmp_we  (w_cmp_we),
        .i_wd      (bus.wd),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_ti      (w_ti)
    );

    // mfc0 read mux
    always_comb begin
        w_rd = '0;
        case (bus.ra)
            REG_BADVADDR: w_rd = r_badvaddr;
            REG_COUNT:    w_rd = w_count;
            REG_COMPARE:  w_rd = w_compare;
            REG_SR:       w_rd = r_sr;
            REG_CAUSE:    w_rd = w_cause;
            REG_EPC:      w_rd = r_epc;
            REG_PRID:     w_rd = PRID_VAL;
            default:      w_rd = '0;
        endcase
    end

    // Architectural state: exception entry, mtc0 writes, eret.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr       <= SR_RESET;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_bd       <= 1'b0;
            r_ip_sw    <= '0;
            r_ip_hw    <= '0;
            r_exc_code <= '0;
        end else begin
            r_ip_hw <= bus.hw_int;
            if (w_int_req) begin
                r_epc        <= restart_pc(bus.pc, bus.in_ds);
                r_bd         <= bus.in_ds;
                r_sr[SR_EXL] <= 1'b1;
                r_exc_code   <= w_exc_req ? bus.exc_code_in : EXC_W'(EXC_INT);
                if (w_exc_req && bus.bad_vaddr_vld) begin
                    r_badvaddr <= bus.bad_vaddr_in;
                end
            end else begin
                if (w_wr_ok) begin
                    case (bus.wa)
                        REG_SR:    r_sr    <= bus.wd;
                        REG_CAUSE: r_ip_sw <= bus.wd[CAUSE_IP_LO +: 2];
                        REG_EPC:   r_epc   <= bus.wd;
                        default:   ;
                    endcase
                end
                // Placed after the SR write so eret's EXL clear is final.
                if (bus.eret) begin
                    r_sr[SR_EXL] <= 1'b0;
                end
            end
        end
    end

    assign bus.rd        = w_rd;
    assign bus.int_req   = w_int_req;
    assign bus.epc_out   = r_epc;
    assign bus.timer_irq = w_ti;

endmodule

// File: tb/tb_cp0_v2.sv
// Scoreboard bench for cp0_v2: the driver pushes expected observations into
// a queue each cycle; a negedge monitor pops and compares them.
module tb_cp0_v2;

    logic clk;
    logic reset_n;

    cp0_v2_if #(.N_HWINT(5)) bus ();

    cp0_v2 #(
        .N_HWINT      (5),
        .CNT_DIV_LOG2 (1),
        .PRID_VAL     (32'h2037_3168),
        .SR_RESET     (32'h0000_FF11)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    localparam int SEL_RD  = 0;
    localparam int SEL_INT = 1;
    localparam int SEL_EPC = 2;
    localparam int SEL_TI  = 3;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            c = sb_q.pop_front();
            case (c.sel)
                SEL_RD:  act = bus.rd;
                SEL_INT: act = {31'd0, bus.int_req};
                SEL_EPC: act = bus.epc_out;
                default: act = {31'd0, bus.timer_irq};
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s actual=%h expected=%h t=%0t", c.name, act, c.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb_q.push_back(c);
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        bus.ra = a;
        expect_sig(SEL_RD, exp, name);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.wa = a;
        bus.wd = d;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ra = '0; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.pc = '0; bus.in_ds = 1'b0; bus.exc_code_in = '0;
        bus.bad_vaddr_vld = 1'b0; bus.bad_vaddr_in = '0;
        bus.hw_int = '0; bus.eret = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset values
        rd_chk(5'd12, 32'h0000_FF11, "sr_rst"); expect_sig(SEL_INT, 0, "intreq_rst"); tick();
        rd_chk(5'd11, 32'hFFFF_FFFF, "compare_rst"); expect_sig(SEL_TI, 0, "ti_rst"); tick();
        rd_chk(5'd15, 32'h2037_3168, "prid"); tick();
        rd_chk(5'd3,  32'h0, "unmapped_rd"); tick();
        rd_chk(5'd13, 32'h0, "cause_rst"); tick();
        rd_chk(5'd14, 32'h0, "epc_rst"); expect_sig(SEL_EPC, 0, "epc_out_rst"); tick();
        rd_chk(5'd8,  32'h0, "badvaddr_rst"); tick();

        // Device interrupt from a delay slot
        mtc0(5'd12, 32'h0000_0401);
        bus.hw_int = 5'b00001; bus.pc = 32'h0000_3010; bus.in_ds = 1'b1;
        expect_sig(SEL_INT, 0, "dev_latency"); tick();
        expect_sig(SEL_INT, 1, "dev_req"); expect_sig(SEL_EPC, 0, "epc_before"); tick();
        expect_sig(SEL_INT, 0, "dev_exl_mask"); expect_sig(SEL_EPC, 32'h0000_300C, "epc_ds");
        rd_chk(5'd13, 32'h8000_0400, "cause_dev"); tick();
        rd_chk(5'd12, 32'h0000_0403, "sr_exl_set");
        bus.hw_int = '0; bus.in_ds = 1'b0; tick();

        // eret, then exception vs device priority with a discarded mtc0
        bus.eret = 1'b1; expect_sig(SEL_INT, 0, "eret_idle"); tick(); bus.eret = 1'b0;
        rd_chk(5'd12, 32'h0000_0401, "sr_after_eret");
        bus.hw_int = 5'b00001; expect_sig(SEL_INT, 0, "dev2_latency"); tick();
        bus.exc_code_in = 5'd12; bus.pc = 32'h0000_4000;
        bus.bad_vaddr_vld = 1'b1; bus.bad_vaddr_in = 32'h0000_1234;
        bus.we = 1'b1; bus.wa = 5'd14; bus.wd = 32'hDEAD_BEEF;
        expect_sig(SEL_INT, 1, "exc_req"); tick();
        bus.we = 1'b0; bus.exc_code_in = '0; bus.bad_vaddr_vld = 1'b0;
        rd_chk(5'd14, 32'h0000_4000, "epc_exc_discard"); expect_sig(SEL_INT, 0, "exc_exl_mask"); tick();
        rd_chk(5'd13, 32'h0000_0430, "cause_exc"); tick();
        rd_chk(5'd8, 32'h0000_1234, "badvaddr_cap"); bus.hw_int = '0; tick();
        rd_chk(5'd12, 32'h0000_0403, "sr_exc"); tick();

        // Timer: Count=0, Compare=5, prescale by 2
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        for (int i = 0; i < 10; i++) begin
            expect_sig(SEL_TI, 0, "ti_wait");
            tick();
        end
        expect_sig(SEL_TI, 1, "ti_set"); expect_sig(SEL_INT, 1, "timer_int"); tick();
        rd_chk(5'd13, 32'h4000_8000, "cause_ti"); expect_sig(SEL_TI, 1, "ti_hold"); tick();
        mtc0(5'd11, 32'h0000_0100);
        expect_sig(SEL_TI, 0, "ti_clear"); rd_chk(5'd11, 32'h0000_0100, "compare_wr"); tick();

        // Software interrupt and eret override
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100);
        expect_sig(SEL_INT, 1, "sw_req"); tick();
        expect_sig(SEL_INT, 0, "sw_exl_mask"); bus.eret = 1'b1; tick();
        expect_sig(SEL_INT, 0, "eret_wins"); rd_chk(5'd12, 32'h0000_0101, "sr_eret_exl0"); tick();
        bus.eret = 1'b0;
        expect_sig(SEL_INT, 1, "sw_retake"); rd_chk(5'd13, 32'h0000_0100, "cause_sw"); tick();
        mtc0(5'd13, 32'h0);
        rd_chk(5'd13, 32'h0, "cause_sw_clr"); tick();

        // Reset in the same cycle as an exception
        mtc0(5'd12, 32'h0000_0001);
        bus.exc_code_in = 5'd4; bus.pc = 32'h0000_5000; reset_n = 1'b0; tick();
        reset_n = 1'b1; bus.exc_code_in = '0;
        expect_sig(SEL_EPC, 0, "epc_reset_wins"); rd_chk(5'd12, 32'h0000_FF11, "sr_reset_wins");
        expect_sig(SEL_INT, 0, "int_after_rst"); tick();
        rd_chk(5'd8, 32'h0, "badvaddr_reset_wins"); tick();

        // Count write and unmapped write
        mtc0(5'd9, 32'h0000_0100);
        rd_chk(5'd9, 32'h0000_0100, "count_wr"); tick();
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd_chk(5'd3, 32'h0, "unmapped_wr"); tick();

        tick();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_v2.md
Name: cp0_v2

Overview:
- Second-generation coprocessor-0 for the P7 pipelined CPU.
- Holds SR, Cause, EPC and PRId, plus a new on-chip Count/Compare timer and BadVAddr.
- Generalises the hardware-interrupt line count and adds software interrupts.
- Sits beside the M stage: takes the committing PC, the exception code and the delay-slot flag; returns int_req and epc_out to the pipeline controller.

Parameters:
- N_HWINT, 5, number of external interrupt lines (1..5); mapped to IP/IM bits [10+N_HWINT-1:10]
- CNT_DIV_LOG2, 1, Count increments once every 2^CNT_DIV_LOG2 clocks (0 = every clock)
- PRID_VAL, 32'h2037_3168, reset and read value of PRId
- SR_RESET, 32'h0000_FF11, reset value of SR

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active-low
- ra  in  5  read address
- rd  out  32  read data, combinational from ra
- we  in  1  mtc0 write enable
- wa  in  5  write address
- wd  in  32  write data
- pc  in  32  PC of the instruction in M
- in_ds  in  1  M instruction is in a branch delay slot
- exc_code_in  in  5  synchronous exception code; 0 = none
- bad_vaddr_vld  in  1  exception carries a faulting address
- bad_vaddr_in  in  32  faulting address
- hw_int  in  N_HWINT  external interrupt lines, level-sensitive
- eret  in  1  eret committing in M
- int_req  out  1  take exception/interrupt this cycle (combinational)
- epc_out  out  32  current EPC
- timer_irq  out  1  Cause.TI, registered

Behaviour:
- Register map:
  - 8 BadVAddr (read-only)
  - 9 Count
  - 11 Compare
  - 12 SR
  - 13 Cause
  - 14 EPC
  - 15 PRId (read-only)
  - Any other address reads 32'h0; writes to it are ignored.
- Field layout:
  - SR: IE=bit0, EXL=bit1, IM=[15:8].
  - Cause: BD=31, TI=30, IP=[15:8], ExcCode=[6:2].
  - IP[9:8] are software interrupts; IP[10+N_HWINT-1:10] follow hw_int; IP[15] mirrors TI; remaining IP bits read 0.
- Reset (reset_n==0 at posedge):
  - SR=SR_RESET, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=32'hFFFF_FFFF, prescaler=0.
  - timer_irq=0. int_req evaluates combinationally from the reset state.
  - Reset overrides every other event in that cycle.
- Interrupt sampling: hw_int is registered into Cause.IP each cycle, so a request is visible to int_req one clock after the line rises.
- Requests (all combinational):
  - pend = |(IP & IM)
  - dev_req = pend & IE & ~EXL
  - exc_req = (exc_code_in!=0) & ~EXL
  - int_req = (dev_req | exc_req) & ~eret
- Priority on a cycle with int_req: exc_req over dev_req.
  - EPC <= in_ds ? pc-4 : pc
  - BD <= in_ds
  - EXL <= 1
  - ExcCode <= exc_req ? exc_code_in : 0
  - BadVAddr <= bad_vaddr_in only if exc_req & bad_vaddr_vld
- eret clears EXL. eret in the same cycle as a pending request: eret wins, and the request is re-evaluated next cycle.
- mtc0 (we):
  - SR: full write.
  - Cause: only [9:8] writable.
  - EPC: full write.
  - Count: full write; also clears the prescaler.
  - Compare: full write; also clears TI.
  - If int_req is asserted in the same cycle, the write is discarded (the faulting instruction does not commit).
- Timer:
  - The prescaler counts 0..2^CNT_DIV_LOG2-1; Count increments when it wraps, modulo 2^32.
  - TI sets on the clock after Count==Compare becomes true. It stays set until Compare is written.
  - If the set and the Compare write land on the same cycle, the write wins.
  - timer_irq = TI.
- Simultaneous mtc0 to Count and the increment: the written value wins.

Decomposition:
- Shared package cp0_pkg:
  - register-address constants (8, 9, 11..15)
  - SR/Cause bit-position constants
  - ExcCode values (Int=0, AdEL=4, AdES=5, RI=10, Ov=12)
- One sub-module, cp0_timer:
  - contains the prescaler, Count, Compare and TI
  - inputs: write strobes and data
  - outputs: Count, Compare, TI

Test Plan:
- Reset: hold reset_n=0 two clocks → SR reads 32'h0000_FF11, Compare reads 32'hFFFF_FFFF, PRId reads 32'h2037_3168, address 3 reads 0, int_req=0.
- Device interrupt, in_ds=1: raise hw_int[0] with IM[10]=1, IE=1, pc=32'h0000_3010 → int_req asserts one clock later; EPC becomes 32'h0000_300C, BD=1, ExcCode=0, EXL=1; the next cycle int_req=0.
- Priority and write discard: exc_code_in=12 together with a pending device interrupt and we to EPC → ExcCode=12, EPC=pc, and the mtc0 write is discarded.
- Timer, CNT_DIV_LOG2=1: write Compare=5, Count=0, IM[15]=1 → TI and timer_irq rise about 11 clocks later; int_req asserts; writing Compare clears TI.
- Software interrupt and eret: write Cause=32'h0000_0100 with IM[8]=1 → int_req; eret in a cycle where the request is still pending → EXL=0 and int_req=0 that cycle, then int_req asserts again the next cycle.
- Reset mid-exception: reset_n=0 on the same cycle as exc_req → EPC=0, EXL=SR_RESET[1], no state is captured.
